// File: rtl/systolic_core_nxn.sv
// Output-stationary N x N systolic matrix-multiply core with skewing input serializer.
// Define SYSTOLIC_CORE_SAT_EN to clamp scaled results instead of wrapping them.
module systolic_core_nxn #(
  parameter int WIDTH           = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] input_w,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] input_n,
  output logic                                  out_valid,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out,
  output logic                                  busy
);
  localparam int N          = BLOCK_SIZE;
  localparam int TILES      = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ACC_WIDTH  = 2*WIDTH + $clog2(INNER_DIMENSION);
  localparam int TOT        = WIDTH*N*N;
  localparam int FCW        = (N > 1) ? $clog2(N) : 1;
  localparam int TCW        = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int DCW        = $clog2(2*N) + 1;
  localparam int DRAIN_LAST = (N > 1) ? 2*(N-1) - 1 : 0;

  typedef enum logic [2:0] {IDLE, FEED, WAIT, DRAIN, DONE} state_t;

  state_t             state;
  logic [FCW-1:0]     feed_cnt;
  logic [TCW-1:0]     tile_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic               out_valid_r;
  logic               accept;
  logic               advance;

  logic signed [WIDTH-1:0]     a_tile [N][N];
  logic signed [WIDTH-1:0]     b_tile [N][N];
  logic signed [WIDTH-1:0]     a_inj  [N];
  logic signed [WIDTH-1:0]     b_inj  [N];
  logic signed [WIDTH-1:0]     a_sk   [N][N];
  logic signed [WIDTH-1:0]     b_sk   [N][N];
  logic signed [WIDTH-1:0]     west   [N];
  logic signed [WIDTH-1:0]     north  [N];
  logic signed [WIDTH-1:0]     a_in   [N][N];
  logic signed [WIDTH-1:0]     b_in   [N][N];
  logic signed [WIDTH-1:0]     a_pass [N][N];
  logic signed [WIDTH-1:0]     b_pass [N][N];
  logic signed [2*WIDTH-1:0]   prod   [N][N];
  logic signed [ACC_WIDTH-1:0] acc    [N][N];
  logic [TOT-1:0]              out_next;

  assign in_ready = en && !rst &&
                    ((state == IDLE) || (state == WAIT) ||
                     (state == FEED && feed_cnt == FCW'(N-1) && tile_cnt != TCW'(TILES-1)));
  assign accept    = in_valid && in_ready;
  // WAIT freezes the whole array so in-flight operands line up with the next tile
  assign advance   = (state == FEED) || (state == DRAIN);
  assign out_valid = out_valid_r && en;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      feed_cnt    <= '0;
      tile_cnt    <= '0;
      drain_cnt   <= '0;
      out_valid_r <= 1'b0;
      out         <= '0;
    end else if (en) begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state    <= FEED;
          feed_cnt <= '0;
          tile_cnt <= '0;
        end
        FEED: if (feed_cnt == FCW'(N-1)) begin
          feed_cnt <= '0;
          if (accept) begin
            tile_cnt <= tile_cnt + 1'b1;
          end else if (tile_cnt == TCW'(TILES-1)) begin
            state     <= (N == 1) ? DONE : DRAIN;
            drain_cnt <= '0;
          end else begin
            state <= WAIT;
          end
        end else begin
          feed_cnt <= feed_cnt + 1'b1;
        end
        WAIT: if (accept) begin
          state    <= FEED;
          feed_cnt <= '0;
          tile_cnt <= tile_cnt + 1'b1;
        end
        DRAIN: if (drain_cnt == DCW'(DRAIN_LAST)) state <= DONE;
               else drain_cnt <= drain_cnt + 1'b1;
        DONE: begin
          out         <= out_next;
          out_valid_r <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++) begin
          a_tile[r][k] <= '0;
          b_tile[r][k] <= '0;
        end
    end else if (accept) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++) begin
          a_tile[r][k] <= input_w[TOT-1-WIDTH*(r*N+k) -: WIDTH];
          b_tile[r][k] <= input_n[TOT-1-WIDTH*(r*N+k) -: WIDTH];
        end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      if (state == FEED) begin
        a_inj[i] = a_tile[i][feed_cnt];
        b_inj[i] = b_tile[feed_cnt][i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_skew
    if (g == 0) begin : g_direct
      assign west[g]  = a_inj[g];
      assign north[g] = b_inj[g];
    end else begin : g_delayed
      assign west[g]  = a_sk[g][g-1];
      assign north[g] = b_sk[g][g-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_w
        assign a_in[r][c] = west[r];
      end else begin : g_e
        assign a_in[r][c] = a_pass[r][c-1];
      end
      if (r == 0) begin : g_n
        assign b_in[r][c] = north[c];
      end else begin : g_s
        assign b_in[r][c] = b_pass[r-1][c];
      end
      assign prod[r][c] = a_in[r][c] * b_in[r][c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_sk[r][c]   <= '0;
          b_sk[r][c]   <= '0;
          a_pass[r][c] <= '0;
          b_pass[r][c] <= '0;
          acc[r][c]    <= '0;
        end
    end else if (en) begin
      if (state == DONE) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            a_sk[r][c]   <= '0;
            b_sk[r][c]   <= '0;
            a_pass[r][c] <= '0;
            b_pass[r][c] <= '0;
            acc[r][c]    <= '0;
          end
      end else if (advance) begin
        for (int r = 0; r < N; r++) begin
          a_sk[r][0] <= a_inj[r];
          b_sk[r][0] <= b_inj[r];
          for (int j = 1; j < N; j++) begin
            a_sk[r][j] <= a_sk[r][j-1];
            b_sk[r][j] <= b_sk[r][j-1];
          end
          for (int c = 0; c < N; c++) begin
            a_pass[r][c] <= a_in[r][c];
            b_pass[r][c] <= b_in[r][c];
            acc[r][c]    <= acc[r][c] +
                            {{(ACC_WIDTH-2*WIDTH){prod[r][c][2*WIDTH-1]}}, prod[r][c]};
          end
        end
      end
    end
  end

`ifdef SYSTOLIC_CORE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] res;
  always_comb begin
    out_next = '0;
    res      = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        res = acc[r][c] >>> FRAC_WIDTH;
        if (res > SAT_MAX)      out_next[TOT-1-WIDTH*(r*N+c) -: WIDTH] = SAT_MAX[WIDTH-1:0];
        else if (res < SAT_MIN) out_next[TOT-1-WIDTH*(r*N+c) -: WIDTH] = SAT_MIN[WIDTH-1:0];
        else                    out_next[TOT-1-WIDTH*(r*N+c) -: WIDTH] = res[WIDTH-1:0];
      end
  end
`else
  always_comb begin
    out_next = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        out_next[TOT-1-WIDTH*(r*N+c) -: WIDTH] = WIDTH'(acc[r][c] >>> FRAC_WIDTH);
  end
`endif

endmodule

// File: tb/tb_systolic_core_nxn.sv
// Directed bench for systolic_core_nxn: one K=2 and one K=4 instance, N=2, Q8.8.
module tb_systolic_core_nxn;
  logic        clk = 1'b0;
  logic        rst, en;
  logic        iv2, iv4;
  logic [63:0] inw, inn;
  logic        ir2, ir4, ov2, ov4, busy2, busy4;
  logic [63:0] out2, out4;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          t0, lat, stale;
  logic [63:0] sat_exp;

  localparam logic [63:0] A1 = 64'h0100_0200_0300_0400;
  localparam logic [63:0] B1 = 64'h0500_0600_0700_0800;
  localparam logic [63:0] C1 = 64'h1300_1600_2B00_3200;
  localparam logic [63:0] C2 = 64'h2600_2C00_5600_6400;
  localparam logic [63:0] AI = 64'h0100_0000_0000_0100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  systolic_core_nxn #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .INNER_DIMENSION(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv2), .in_ready(ir2), .input_w(inw),
    .input_n(inn), .out_valid(ov2), .out(out2), .busy(busy2));

  systolic_core_nxn #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .INNER_DIMENSION(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv4), .in_ready(ir4), .input_w(inw),
    .input_n(inn), .out_valid(ov4), .out(out4), .busy(busy4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns cycles elapsed since t0 when out_valid is seen, bounded
  task automatic wait_ov(input int sel, output int cycles);
    int n = 0;
    while (!((sel == 2) ? ov2 : ov4) && n < 60) begin
      @(negedge clk);
      n++;
    end
    cycles = cyc - t0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; iv2 = 1'b0; iv4 = 1'b0; inw = '0; inn = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", {63'd0, ir2}, 64'd0);
    chk("rst_out_valid", {63'd0, ov2}, 64'd0);
    chk("rst_out", out2, 64'd0);
    chk("rst_busy", {63'd0, busy2}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, ir2}, 64'd1);

    // single tile, K=2
    inw = A1; inn = B1; iv2 = 1'b1;
    @(negedge clk); t0 = cyc; iv2 = 1'b0; inw = '0; inn = '0;
    chk("t1_busy", {63'd0, busy2}, 64'd1);
    wait_ov(2, lat);
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_out", out2, C1);
    @(negedge clk);
    chk("t1_pulse_one_cycle", {63'd0, ov2}, 64'd0);
    chk("t1_out_hold", out2, C1);
    chk("t1_idle", {63'd0, busy2}, 64'd0);

    // back-to-back pair, K=4
    inw = A1; inn = B1; iv4 = 1'b1;
    chk("b2b_ready_idle", {63'd0, ir4}, 64'd1);
    @(negedge clk);
    chk("b2b_ready_feed0", {63'd0, ir4}, 64'd0);
    @(negedge clk);
    chk("b2b_ready_feed_last", {63'd0, ir4}, 64'd1);
    @(negedge clk); t0 = cyc; iv4 = 1'b0;
    chk("b2b_ready_tile1_feed0", {63'd0, ir4}, 64'd0);
    @(negedge clk);
    chk("b2b_ready_final_tile", {63'd0, ir4}, 64'd0);
    wait_ov(4, lat);
    chk("b2b_latency", 64'(lat), 64'd5);
    chk("b2b_out", out4, C2);
    @(negedge clk);

    // gap of 3 idle in_valid cycles between tiles, K=4
    inw = A1; inn = B1; iv4 = 1'b1;
    @(negedge clk); t0 = cyc; iv4 = 1'b0;
    @(negedge clk);
    chk("gap_ready_feed_last", {63'd0, ir4}, 64'd1);
    @(negedge clk);
    chk("gap_wait_busy", {63'd0, busy4}, 64'd1);
    chk("gap_wait_ready", {63'd0, ir4}, 64'd1);
    @(negedge clk);
    @(negedge clk); iv4 = 1'b1;
    @(negedge clk); iv4 = 1'b0;
    wait_ov(4, lat);
    chk("gap_latency", 64'(lat), 64'd10);
    chk("gap_out", out4, C2);
    @(negedge clk);

    // enable dropped for 4 cycles during DRAIN, K=2
    inw = A1; inn = B1; iv2 = 1'b1;
    @(negedge clk); t0 = cyc; iv2 = 1'b0;
    @(negedge clk);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("en_low_ready_gated", {63'd0, ir4}, 64'd0);
    chk("en_low_busy", {63'd0, busy2}, 64'd1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_ov(2, lat);
    chk("en_latency", 64'(lat), 64'd9);
    chk("en_out", out2, C1);
    @(negedge clk);

    // 0x7F00 everywhere: wraps or saturates
`ifdef SYSTOLIC_CORE_SAT_EN
    sat_exp = 64'h7FFF_7FFF_7FFF_7FFF;
`else
    sat_exp = 64'h0200_0200_0200_0200;
`endif
    inw = 64'h7F00_7F00_7F00_7F00; inn = 64'h7F00_7F00_7F00_7F00; iv2 = 1'b1;
    @(negedge clk); t0 = cyc; iv2 = 1'b0;
    wait_ov(2, lat);
    chk("big_out", out2, sat_exp);
    @(negedge clk);

    // negative products: shift rounds toward minus infinity
    inw = 64'h0080_0000_0000_0100; inn = 64'hFFFF_0001_0100_FE00; iv2 = 1'b1;
    @(negedge clk); t0 = cyc; iv2 = 1'b0;
    wait_ov(2, lat);
    chk("neg_out", out2, 64'hFFFF_0000_0100_FE00);
    @(negedge clk);

    // reset during FEED of tile 1, then fresh batch
    inw = A1; inn = B1; iv4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1; iv4 = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy4}, 64'd0);
    chk("abort_out_cleared", out4, 64'd0);
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov4) stale++;
    end
    chk("abort_no_stale_valid", 64'(stale), 64'd0);
    inw = AI; inn = B1; iv4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); t0 = cyc; iv4 = 1'b0;
    wait_ov(4, lat);
    chk("fresh_latency", 64'(lat), 64'd5);
    chk("fresh_out", out4, 64'h0A00_0C00_0E00_1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
